// File: rtl/rgb_fader_if.sv
// Command channel of the RGB colour sequencer: one colour/timing command per
// valid/ready transfer.
interface rgb_fader_if #(
  parameter int WIDTH = 8,
  parameter int DIV_W = 16
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_r;
  logic [WIDTH-1:0] cmd_g;
  logic [WIDTH-1:0] cmd_b;
  logic [DIV_W-1:0] cmd_interval;
  logic [DIV_W-1:0] cmd_hold;

  modport master (
    output cmd_valid, cmd_r, cmd_g, cmd_b, cmd_interval, cmd_hold,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_r, cmd_g, cmd_b, cmd_interval, cmd_hold,
    output cmd_ready
  );
endinterface

// File: rtl/rgb_fader.sv
// Colour sequencer: slews r/g/b linearly toward a commanded target, holds it,
// then pulses done. Feeds the duty inputs of the RGB PWM driver.
module rgb_fader #(
  parameter int WIDTH      = 8,
  parameter int DIV_W      = 16,
  parameter int HOLD_SHIFT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  rgb_fader_if.slave       cmd,
  input  logic             abort_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] g_o,
  output logic [WIDTH-1:0] b_o,
  output logic             busy_o,
  output logic             done_o
);
  localparam int HW = DIV_W + HOLD_SHIFT;
  localparam logic [WIDTH-1:0] ONE_W = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FADE = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] r_q, r_d, g_q, g_d, b_q, b_d;
  logic [WIDTH-1:0] tr_q, tr_d, tg_q, tg_d, tb_q, tb_d;
  logic [DIV_W-1:0] ival_q, ival_d, hold_q, hold_d, cnt_q, cnt_d;
  logic [HW-1:0]    hcnt_q, hcnt_d;
  logic             done_q, done_d;
  logic             arrived_s;
  logic [HW-1:0]    hold_last_s;

  // Moving by one only when unequal guarantees no overshoot or wrap.
  function automatic logic [WIDTH-1:0] step_toward(input logic [WIDTH-1:0] cur,
                                                   input logic [WIDTH-1:0] tgt);
    if (cur < tgt) begin
      return cur + ONE_W;
    end else if (cur > tgt) begin
      return cur - ONE_W;
    end else begin
      return cur;
    end
  endfunction

  assign arrived_s   = (r_q == tr_q) && (g_q == tg_q) && (b_q == tb_q);
  assign hold_last_s = (HW'(hold_q) << HOLD_SHIFT) - HW'(1);

  // Next-state and datapath decisions; abort always wins and freezes outputs.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    g_d     = g_q;
    b_d     = b_q;
    tr_d    = tr_q;
    tg_d    = tg_q;
    tb_d    = tb_q;
    ival_d  = ival_q;
    hold_d  = hold_q;
    cnt_d   = cnt_q;
    hcnt_d  = hcnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (cmd.cmd_valid) begin
          tr_d    = cmd.cmd_r;
          tg_d    = cmd.cmd_g;
          tb_d    = cmd.cmd_b;
          ival_d  = cmd.cmd_interval;
          hold_d  = cmd.cmd_hold;
          cnt_d   = '0;
          hcnt_d  = '0;
          state_d = S_FADE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_FADE: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (arrived_s) begin
          if (hold_q != '0) begin
            hcnt_d  = '0;
            state_d = S_HOLD;
          end else begin
            done_d  = 1'b1;
            state_d = S_IDLE;
          end
        end else if (ival_q == '0) begin
          r_d = tr_q;
          g_d = tg_q;
          b_d = tb_q;
        end else if (cnt_q == ival_q - DIV_W'(1)) begin
          cnt_d = '0;
          r_d   = step_toward(r_q, tr_q);
          g_d   = step_toward(g_q, tg_q);
          b_d   = step_toward(b_q, tb_q);
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      S_HOLD: begin
        if (abort_i) begin
          state_d = S_IDLE;
        end else if (hcnt_q == hold_last_s) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          hcnt_d = hcnt_q + HW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, counters, latched command and duty registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
      tr_q    <= '0;
      tg_q    <= '0;
      tb_q    <= '0;
      ival_q  <= '0;
      hold_q  <= '0;
      cnt_q   <= '0;
      hcnt_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      tr_q    <= tr_d;
      tg_q    <= tg_d;
      tb_q    <= tb_d;
      ival_q  <= ival_d;
      hold_q  <= hold_d;
      cnt_q   <= cnt_d;
      hcnt_q  <= hcnt_d;
      done_q  <= done_d;
    end
  end

  assign cmd.cmd_ready = (state_q == S_IDLE);
  assign busy_o        = (state_q != S_IDLE);
  assign done_o        = done_q;
  assign r_o           = r_q;
  assign g_o           = g_q;
  assign b_o           = b_q;
endmodule

// File: doc/rgb_fader.md
# rgb_fader

Command-driven colour sequencer that drives the `r`/`g`/`b` duty inputs of the RGB PWM driver. It accepts one colour command at a time over a valid/ready handshake. It slews each channel linearly toward the commanded target at a programmable rate, holds the target for a programmable time, then signals completion. The PWM driver latches duty values only at its period boundary, so output changes at any cycle are glitch-free downstream.

## Interface
- `WIDTH`, 8: duty width; must match the PWM driver's duty width.
- `DIV_W`, 16: width of the interval and hold fields.
- `HOLD_SHIFT`, 8: hold unit is 2^HOLD_SHIFT clocks.

- `clk`  in  1  system clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `cmd_valid`  in  1  command offered
- `cmd_ready`  out  1  block can accept a command; equals (state == IDLE)
- `cmd_r`, `cmd_g`, `cmd_b`  in  WIDTH  target duty per channel
- `cmd_interval`  in  DIV_W  clocks per ±1 step; 0 = jump to target
- `cmd_hold`  in  DIV_W  hold time in units of 2^HOLD_SHIFT clocks; 0 = no hold
- `abort`  in  1  synchronous abort, return to IDLE
- `r`, `g`, `b`  out  WIDTH  current duty, registered
- `busy`  out  1  state != IDLE
- `done`  out  1  one-cycle pulse on command completion

## Operation
- **State machine:** IDLE, FADE, HOLD.
- **IDLE:**
  - `cmd_ready` = 1.
  - On `cmd_valid & cmd_ready`, latch the targets (tr/tg/tb), the interval I and the hold H.
  - Clear the step counter to 0 and go to FADE.
- **FADE:** evaluate in this order each cycle.
  - **Arrival:** if r==tr, g==tg and b==tb at the start of the cycle, go to HOLD if H != 0. Otherwise go to IDLE and pulse `done`. No step occurs in that cycle.
  - **Jump (I == 0):** load r/g/b with the targets in the first FADE cycle.
  - **Step (I ≥ 1):** the step counter counts 0..I-1. At I-1 it wraps to 0 and a step event fires. On a step event, each channel that differs from its target moves by exactly 1 toward it. Channels already at target do not move.
  - **Arithmetic:** channels never overshoot, wrap, or exceed 2^WIDTH-1.
- **HOLD:**
  - A counter of width DIV_W+HOLD_SHIFT counts H·2^HOLD_SHIFT clocks.
  - On terminal count, go to IDLE and pulse `done`.
- **`done`:** registered. It is high during the first IDLE cycle after completion. `cmd_ready` is also high in that cycle, so back-to-back commands are accepted with no gap.
- **`abort`:** from any state, next state is IDLE.
  - r/g/b keep their current values.
  - No `done` pulse.
  - Any step event coinciding with `abort` is discarded.
  - `abort` in IDLE takes priority over `cmd_valid`: no accept.
- **Command inputs:** ignored outside IDLE.
- **Reset (`rst_n` low, any time including mid-fade):**
  - State = IDLE; r = g = b = 0; `done` = 0; `busy` = 0.
  - `cmd_ready` = 1; all counters and latched targets = 0.

## Timing
- **Accept:** at clock edge k (IDLE, `cmd_valid` high); FADE from edge k+1.
- **Fade duration:** for max channel distance D and I ≥ 1:
  - The first output change occurs I cycles after FADE entry.
  - Target is reached I·D cycles after FADE entry.
  - FADE lasts I·D+1 cycles.
- **Jump (I == 0):** FADE lasts 2 cycles (load, then arrival).
- **Target already equal to current outputs:** FADE lasts 1 cycle.
- **HOLD:** lasts exactly H·2^HOLD_SHIFT cycles.
- **Total cycles from accept edge to `done`-high cycle:**
  - I ≥ 1: (I·D+1) + H·2^HOLD_SHIFT + 1.
  - I == 0: 2 + H·2^HOLD_SHIFT + 1.
- **Output registers:** r/g/b change only on step events, jump load, or reset.

## Test plan
- **Reset:** drive `rst_n` low mid-FADE (r=40 of target 100) -> r/g/b=0, `busy`=0, `cmd_ready`=1 asynchronously; after release, IDLE holds with no output change.
- **Ramp up:** from 0, command r=10/g=0/b=5, I=3, H=0 -> r increments every 3 cycles, b stops at 5 after 15 cycles, r reaches 10 at cycle 30 of FADE; `done` at accept+32; g stays 0 throughout.
- **Ramp down plus hold, HOLD_SHIFT=2:** from r=g=b=255, command all=250, I=1, H=2 -> 5 decrements on consecutive cycles; FADE 6 cycles, HOLD 8 cycles; single `done` pulse.
- **Jump and back-to-back:** I=0 command to (200,100,50), `cmd_valid` held with a second command queued -> outputs load in 1 cycle; `done` cycle also accepts the second command (no idle gap); second command then executes normally.
- **Abort:** assert `abort` mid-FADE at r=7 of target 20, coincident with a step event -> r stays 7, IDLE next cycle, no `done`; a new command then ramps from 7.
- **Wrap and edge values:** target 0 from 255 with I=1 -> decreases monotonically, ends at 0, never wraps; `cmd_valid` pulsed during FADE/HOLD is ignored (`cmd_ready`=0).
